data_memory_bytelane: RTL and testbench
=======================================

// Module: data_memory_bytelane
// PURPOSE
//  Parametrised single-port data memory for the ARM datapath with byte, halfword and word
//  LDR/STR access, sign or zero extension on loads, alignment and range checking, and a
//  hardware clear sequencer that zeroes the array after reset. Sits after the ALU address
//  path and feeds the writeback mux. Read latency is 1 cycle.
// PARAMETERS
//  DEPTH      64      number of 32-bit words (>=2)
//  BASE_ADDR  32'h0   byte address of word 0; must be 4-byte aligned
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  req          in   1   access request; sampled only while busy=0
//  writeEnable  in   1   1=store, 0=load (active-high)
//  size         in   2   00 byte, 01 halfword, 10 word, 11 reserved
//  signedLoad   in   1   1=sign-extend byte/half load, 0=zero-extend
//  address      in   32  byte address
//  dataInput    in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  dataOutput   out  32  load result, registered, held until the next load response
//  readValid    out  1   1-cycle pulse: dataOutput updated for a load
//  error        out  1   1-cycle pulse: rejected access (range, alignment or size=11)
//  busy         out  1   1 while the clear sequence runs; requests are ignored
// BEHAVIOUR
//  Reset (async, asserted): dataOutput=0, readValid=0, error=0, busy=1, state=CLEAR,
//   clearPtr=0. Asserting reset at any time aborts any access and restarts CLEAR.
//  CLEAR: each rising edge writes 0 to word clearPtr and increments clearPtr. On the edge
//   that writes word DEPTH-1, go to READY; busy=0 from the next cycle. The sequence takes
//   exactly DEPTH cycles after reset deasserts. req is ignored: no pulses, no writes.
//  READY: an access is accepted on an edge where req=1 and busy=0.
//  Decode: off = address - BASE_ADDR.
//   In range iff address >= BASE_ADDR and off < 4*DEPTH. Word index = off[..:2].
//   Lane = off[1:0], little-endian: byte k occupies bits [8k+7:8k].
//   Alignment: half needs off[0]=0; word needs off[1:0]=0. size=11 is always an error.
//  Store (valid): only the addressed byte lanes are written at the accepting edge; other
//   lanes are unchanged. readValid=0 and error=0 on the next cycle.
//  Load (valid): on the accepting edge, dataOutput <= extracted lane(s), extended per
//   signedLoad (word ignores signedLoad). readValid=1 for the next cycle.
//  Invalid access: memory unchanged and error=1 for 1 cycle. On a load, readValid=1 and
//   dataOutput=0 in the same cycle, so a stalled pipeline always gets a response.
//  Back-to-back: one access per cycle, no bubbles. A load accepted on the edge after a
//   store to the same word returns the stored data.
//  Between responses, dataOutput holds its value; readValid and error are 0.
// STRUCTURE
//  Package data_mem_pkg:
//   - size codes SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD
//   - state encoding CLEAR / READY
//   - function mem_check(size, lane) -> misaligned
//  Sub-module mem_lane_align (combinational):
//   - store: byte-enable mask and shifted write data
//   - load: lane select and sign/zero extension
//  Top level: array, clear sequencer FSM, range check, output registers.
// TESTING
//  1. Release reset, DEPTH=64 -> busy=1 for exactly 64 cycles; a req during busy gives
//     no readValid/error; afterwards LDR word at 0x0..0xFC all return 0.
//  2. STR word 0x8 = 32'h8081_F2A3; LDRB 0x9 signed -> 32'hFFFF_FFF2;
//     LDRB 0x9 unsigned -> 32'h0000_00F2; LDRH 0xA signed -> 32'hFFFF_8081.
//  3. STRB 0xB = 32'h0000_0055 over 32'h8081_F2A3 -> LDR 0x8 = 32'h5581_F2A3;
//     the STRB is followed by the LDR on the next cycle, with no gap.
//  4. LDR 0x6 -> error=1, readValid=1, dataOutput=0; STRH 0x3 -> error=1, memory unchanged;
//     size=11 -> error=1.
//  5. BASE_ADDR=32'h2000: LDR 0x2100 (off=256=4*DEPTH) -> error=1;
//     LDR 0x1FFC -> error=1; LDR 0x20FC -> readValid=1, error=0.
//  6. Assert reset mid-stream after stores -> outputs 0 immediately; after the clear
//     sequence the previously stored words read back as 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the byte-lane data memory: access size codes,
// sequencer states and the alignment rule.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // A reserved size counts as misaligned, so one flag covers every non-range rejection.
    function automatic logic mem_check(input logic [1:0] size, input logic [1:0] lane);
        logic misaligned;
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
        return misaligned;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// lane extraction with sign or zero extension.
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        signed_load,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;

    // Store path: data is replicated across lanes so the enable mask alone picks the target.
    always_comb begin
        byte_en    = 4'b0000;
        write_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << lane;
                write_data = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                write_data = {2{store_data[15:0]}};
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                write_data = store_data;
            end
            default: begin
                byte_en    = 4'b0000;
                write_data = 32'h0000_0000;
            end
        endcase
    end

    // Load path: select the addressed lane(s) and extend to 32 bits.
    always_comb begin
        byte_sel_s = 8'h00;
        half_sel_s = lane[1] ? read_word[31:16] : read_word[15:0];
        load_data  = 32'h0000_0000;
        case (lane)
            2'd0:    byte_sel_s = read_word[7:0];
            2'd1:    byte_sel_s = read_word[15:8];
            2'd2:    byte_sel_s = read_word[23:16];
            default: byte_sel_s = read_word[31:24];
        endcase
        case (size)
            SZ_BYTE: load_data = signed_load ? {{24{byte_sel_s[7]}}, byte_sel_s}
                                             : {24'h00_0000, byte_sel_s};
            SZ_HALF: load_data = signed_load ? {{16{half_sel_s[15]}}, half_sel_s}
                                             : {16'h0000, half_sel_s};
            SZ_WORD: load_data = read_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Single-port byte/half/word data memory with range and alignment checking
// and a post-reset clear sequencer. Loads respond one cycle after acceptance.
module data_memory_bytelane
    import data_mem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        writeEnable,
    input  logic [1:0]  size,
    input  logic        signedLoad,
    input  logic [31:0] address,
    input  logic [31:0] dataInput,
    output logic [31:0] dataOutput,
    output logic        readValid,
    output logic        error,
    output logic        busy
);

    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]      SPAN     = 32'(4 * DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [31:0]      mem_r [DEPTH];
    state_e           state_r;
    state_e           state_next_s;
    logic [IDX_W-1:0] clear_ptr_r;
    logic             busy_r;
    logic [31:0]      data_out_r;
    logic             read_valid_r;
    logic             error_r;

    logic [31:0]      off_s;
    logic [IDX_W-1:0] idx_s;
    logic             in_range_s;
    logic             invalid_s;
    logic             accept_s;
    logic             store_ok_s;
    logic [3:0]       byte_en_s;
    logic [31:0]      write_data_s;
    logic [31:0]      load_data_s;
    logic [31:0]      read_word_s;

    assign off_s       = address - BASE_ADDR;
    assign idx_s       = off_s[IDX_W+1:2];
    assign read_word_s = mem_r[idx_s];

    // Access decode: the address must not sit below the base and the offset must fit the array.
    always_comb begin
        in_range_s = 1'b0;
        invalid_s  = 1'b1;
        accept_s   = 1'b0;
        store_ok_s = 1'b0;
        in_range_s = (address >= BASE_ADDR) && (off_s < SPAN);
        invalid_s  = !in_range_s || mem_check(size, off_s[1:0]);
        accept_s   = req && (state_r == READY) && !busy_r;
        store_ok_s = accept_s && writeEnable && !invalid_s;
    end

    mem_lane_align u_align (
        .size        (size),
        .lane        (off_s[1:0]),
        .signed_load (signedLoad),
        .store_data  (dataInput),
        .read_word   (read_word_s),
        .byte_en     (byte_en_s),
        .write_data  (write_data_s),
        .load_data   (load_data_s)
    );

    // Clear sequencer next state: leave CLEAR on the edge that zeroes the last word.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CLEAR: begin
                if (clear_ptr_r == LAST_IDX) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            READY:   state_next_s = READY;
            default: state_next_s = CLEAR;
        endcase
    end

    // Sequencer state, clear pointer and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= CLEAR;
            clear_ptr_r <= '0;
            busy_r      <= 1'b1;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == CLEAR);
            if (state_r == CLEAR) begin
                clear_ptr_r <= clear_ptr_r + 1'b1;
            end
        end
    end

    // Storage array: zero-fill while clearing, otherwise byte-enabled stores.
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem_r[clear_ptr_r] <= 32'h0000_0000;
        end else if (store_ok_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= write_data_s[8*b +: 8];
                end
            end
        end
    end

    // Response registers; a rejected load still answers, with zero data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_r   <= 32'h0000_0000;
            read_valid_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            read_valid_r <= accept_s && !writeEnable;
            error_r      <= accept_s && invalid_s;
            if (accept_s && !writeEnable) begin
                data_out_r <= invalid_s ? 32'h0000_0000 : load_data_s;
            end
        end
    end

    assign dataOutput = data_out_r;
    assign readValid  = read_valid_r;
    assign error      = error_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Randomized self-checking bench: a byte-array reference model predicts every
// response; a second instance with a non-zero base covers the range edges.
module tb_data_memory_bytelane;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req1;
    logic        writeEnable;
    logic [1:0]  size;
    logic        signedLoad;
    logic [31:0] address;
    logic [31:0] address1;
    logic [31:0] dataInput;
    logic [31:0] dataOutput, dataOutput1;
    logic        readValid, readValid1;
    logic        error, error1;
    logic        busy, busy1;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  ref_b [256];
    logic [31:0] exp_dout;
    logic [31:0] got;

    always #5 clk = ~clk;

    data_memory_bytelane #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .req(req), .writeEnable(writeEnable), .size(size),
        .signedLoad(signedLoad), .address(address), .dataInput(dataInput),
        .dataOutput(dataOutput), .readValid(readValid), .error(error), .busy(busy)
    );

    data_memory_bytelane #(.DEPTH(64), .BASE_ADDR(32'h0000_2000)) dut_base (
        .clk(clk), .reset(reset), .req(req1), .writeEnable(writeEnable), .size(size),
        .signedLoad(signedLoad), .address(address1), .dataInput(dataInput),
        .dataOutput(dataOutput1), .readValid(readValid1), .error(error1), .busy(busy1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input int off);
        longint v;
        case (sz)
            2'd0: begin
                v = ref_b[off];
                if (sg && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = ref_b[off] + 256 * ref_b[off+1];
                if (sg && v >= 32768) v = v - 65536;
            end
            default: v = ref_b[off] + 256 * ref_b[off+1] + 65536 * ref_b[off+2]
                         + 16777216 * longint'(ref_b[off+3]);
        endcase
        return 32'(v);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
        exp_dout = 32'h0000_0000;
    endtask

    // One access on the base-0 instance; response is checked one cycle later.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] obs);
        longint off;
        logic   bad;
        off = longint'({32'h0, a});
        bad = (off >= 256) || (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0)
              || (sz == 2'd2 && off % 4 != 0);
        if (!we) begin
            exp_dout = bad ? 32'h0000_0000 : model_load(sz, sg, int'(off));
        end else if (!bad) begin
            for (int k = 0; k < (1 << sz); k++) ref_b[int'(off) + k] = d[8*k +: 8];
        end
        req = 1'b1; writeEnable = we; size = sz; signedLoad = sg; address = a; dataInput = d;
        @(posedge clk); #1;
        req = 1'b0;
        check_val($sformatf("readValid we=%0d sz=%0d a=%08h", we, sz, a), {31'h0, readValid}, {31'h0, !we});
        check_val($sformatf("error we=%0d sz=%0d a=%08h", we, sz, a), {31'h0, error}, {31'h0, bad});
        check_val($sformatf("dataOutput we=%0d sz=%0d a=%08h", we, sz, a), dataOutput, exp_dout);
        obs = dataOutput;
    endtask

    task automatic idle();
        req = 1'b0;
        @(posedge clk); #1;
        check_val("idle readValid", {31'h0, readValid}, 32'h0);
        check_val("idle error", {31'h0, error}, 32'h0);
        check_val("idle dataOutput hold", dataOutput, exp_dout);
    endtask

    task automatic issue_base(input logic [31:0] a, input logic exp_err);
        writeEnable = 1'b0; size = 2'd2; signedLoad = 1'b0; address1 = a; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        check_val($sformatf("base readValid a=%08h", a), {31'h0, readValid1}, 32'h1);
        check_val($sformatf("base error a=%08h", a), {31'h0, error1}, {31'h0, exp_err});
        check_val($sformatf("base dataOutput a=%08h", a), dataOutput1, 32'h0);
    endtask

    // Counts cycles until busy drops, with a bound; req stays high to prove it is ignored.
    task automatic wait_clear(input string tag);
        int cnt;
        int spurious;
        cnt = 0; spurious = 0;
        req = 1'b1; req1 = 1'b1; writeEnable = 1'b0; size = 2'd2; address = 32'h0; address1 = 32'h2000;
        while (busy && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (readValid || error || readValid1 || error1) spurious++;
        end
        req = 1'b0; req1 = 1'b0;
        check_val({tag, " busy cycles"}, 32'(cnt), 32'd64);
        check_val({tag, " req ignored while busy"}, 32'(spurious), 32'd0);
        check_val({tag, " base busy"}, {31'h0, busy1}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b0; req1 = 1'b0; writeEnable = 1'b0; size = 2'd0;
        signedLoad = 1'b0; address = 32'h0; address1 = 32'h0; dataInput = 32'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset dataOutput", dataOutput, 32'h0);
        check_val("reset readValid", {31'h0, readValid}, 32'h0);
        check_val("reset error", {31'h0, error}, 32'h0);
        check_val("reset busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        wait_clear("initial");

        for (int i = 0; i < 64; i++) issue(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0, got);

        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h8081_F2A3, got);
        issue(1'b0, 2'd0, 1'b1, 32'h9, 32'h0, got);
        check_val("ldrb signed 0x9", got, 32'hFFFF_FFF2);
        issue(1'b0, 2'd0, 1'b0, 32'h9, 32'h0, got);
        check_val("ldrb unsigned 0x9", got, 32'h0000_00F2);
        issue(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, got);
        check_val("ldrh signed 0xA", got, 32'hFFFF_8081);

        issue(1'b1, 2'd0, 1'b0, 32'hB, 32'h0000_0055, got);
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, got);
        check_val("strb then ldr 0x8", got, 32'h5581_F2A3);

        issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, got);
        check_val("misaligned ldr data", got, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h3, 32'h0000_FFFF, got);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, got);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, got);
        idle();
        idle();

        issue_base(32'h0000_2100, 1'b1);
        issue_base(32'h0000_1FFC, 1'b1);
        issue_base(32'h0000_20FC, 1'b0);

        for (int n = 0; n < 600; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) begin
                idle();
            end else begin
                sz = 2'($urandom_range(0, 3));
                a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 271));
                if ($urandom_range(0, 3) != 0) a = a & ~(32'((1 << sz) - 1));
                issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
            end
        end

        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, got);
        issue(1'b1, 2'd2, 1'b0, 32'h24, 32'h1234_5678, got);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);
        check_val("pre-reset ldr 0x20", got, 32'hDEAD_BEEF);
        #2 reset = 1'b1;
        #1;
        check_val("async reset dataOutput", dataOutput, 32'h0);
        check_val("async reset readValid", {31'h0, readValid}, 32'h0);
        check_val("async reset busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        wait_clear("after reset");
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);
        check_val("cleared ldr 0x20", got, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, got);
        check_val("cleared ldr 0x24", got, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
